// File: rtl/p_mul_issue.sv
// p_mul_issue: small issue FIFO in front of the packed multiplier.
//
// Requests are taken from the upstream handshake and checked. A request is kept only when
// in_pw is exactly one-hot and in_mul_l != in_mul_h. A rejected request still completes its
// handshake, is dropped, and raises err for exactly the following cycle. Kept requests are
// queued in order and presented to the multiplier from the head entry. There is no bypass,
// so a queued request reaches mul_valid one cycle after it is accepted.
//
// Parameters:
//   DEPTH       FIFO entry count, 2 or 4.
//
// Ports:
//   clock       sole clock, rising edge.
//   resetn      asynchronous active-low reset.
//   flush       (only with P_MUL_ISSUE_FLUSH_EN) empties the FIFO. Any same-cycle push or
//               error is ignored.
//   in_*        upstream request: in_valid/in_ready handshake, op flags, one-hot pack width
//               and the two 32-bit operands.
//   mul_*, pw, crs1, crs2, clmul
//               downstream request to the multiplier. Payload is held while stalled and is
//               zero when the FIFO is empty.
//   err         one-cycle pulse after a rejected request.
//   count       number of occupied entries.
//
// Optional feature macro: P_MUL_ISSUE_FLUSH_EN (adds the flush port and its logic).

module p_mul_issue #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clock,
  input  logic        resetn,
`ifdef P_MUL_ISSUE_FLUSH_EN
  input  logic        flush,
`endif
  // Upstream request
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mul_l,
  input  logic        in_mul_h,
  input  logic        in_clmul,
  input  logic [4:0]  in_pw,
  input  logic [31:0] in_crs1,
  input  logic [31:0] in_crs2,
  // Downstream request to the packed multiplier
  output logic        mul_valid,
  input  logic        mul_ready,
  output logic        mul_l,
  output logic        mul_h,
  output logic        clmul,
  output logic [4:0]  pw,
  output logic [31:0] crs1,
  output logic [31:0] crs2,
  // Status
  output logic        err,
  output logic [2:0]  count
);

  // DEPTH is restricted to powers of two, so the pointers wrap by plain overflow.
  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam logic [2:0]  DepthCnt = 3'(DEPTH);

  typedef logic [PtrW-1:0] ptr_t;

  typedef struct packed {
    logic        mul_l;
    logic        mul_h;
    logic        clmul;
    logic [4:0]  pw;
    logic [31:0] crs1;
    logic [31:0] crs2;
  } entry_t;

  entry_t     mem_q [DEPTH];
  ptr_t       head_q, head_d;
  ptr_t       tail_q, tail_d;
  logic [2:0] count_q, count_d;
  logic       err_q, err_d;

  logic   accept;
  logic   req_ok;
  logic   push;
  logic   pop;
  logic   flush_req;
  entry_t wr_entry;
  entry_t head_entry;

  // Ready depends only on registered occupancy, never on mul_ready.
  assign in_ready  = (count_q < DepthCnt);
  assign mul_valid = (count_q != 3'd0);
  assign count     = count_q;
  assign err       = err_q;

`ifdef P_MUL_ISSUE_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // One-hot test without $onehot: non-zero and only a single bit set.
  assign req_ok = (in_pw != 5'd0) && ((in_pw & (in_pw - 5'd1)) == 5'd0) &&
                  (in_mul_l != in_mul_h);

  assign accept = in_valid && in_ready;
  assign push   = accept && req_ok && !flush_req;
  assign pop    = mul_valid && mul_ready && !flush_req;

  assign wr_entry = '{
    mul_l: in_mul_l,
    mul_h: in_mul_h,
    clmul: in_clmul,
    pw:    in_pw,
    crs1:  in_crs1,
    crs2:  in_crs2
  };

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = 1'b0;
    if (flush_req) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = 3'd0;
    end else begin
      if (pop) begin
        head_d = head_q + ptr_t'(1);
      end
      if (push) begin
        tail_d = tail_q + ptr_t'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
      // The rejected request still handshakes, so err follows the accept.
      err_d = accept && !req_ok;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage needs no reset: an empty FIFO masks the payload to zero below.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[tail_q] <= wr_entry;
    end
  end

  assign head_entry = mem_q[head_q];

  // Payload comes from the head entry and is zero while empty. This covers reset,
  // because count_q clears asynchronously.
  always_comb begin
    mul_l = 1'b0;
    mul_h = 1'b0;
    clmul = 1'b0;
    pw    = 5'd0;
    crs1  = 32'd0;
    crs2  = 32'd0;
    if (mul_valid) begin
      mul_l = head_entry.mul_l;
      mul_h = head_entry.mul_h;
      clmul = head_entry.clmul;
      pw    = head_entry.pw;
      crs1  = head_entry.crs1;
      crs2  = head_entry.crs2;
    end
  end

endmodule

// File: tb/tb_p_mul_issue.sv
// Self-checking bench for p_mul_issue. Directed steps are followed by random traffic.
// Everything is compared against a queue-based reference model.
module tb_p_mul_issue;

  localparam int DEPTH = 2;

  logic        clock;
  logic        resetn;
`ifdef P_MUL_ISSUE_FLUSH_EN
  logic        flush;
`endif
  logic        in_valid, in_ready, in_mul_l, in_mul_h, in_clmul;
  logic [4:0]  in_pw;
  logic [31:0] in_crs1, in_crs2;
  logic        mul_valid, mul_ready, mul_l, mul_h, clmul;
  logic [4:0]  pw;
  logic [31:0] crs1, crs2;
  logic        err;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of 72-bit payloads {mul_l, mul_h, clmul, pw, crs1, crs2}.
  logic [71:0] mq[$];
  logic        err_m;

  p_mul_issue #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .resetn    (resetn),
`ifdef P_MUL_ISSUE_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mul_l  (in_mul_l),
    .in_mul_h  (in_mul_h),
    .in_clmul  (in_clmul),
    .in_pw     (in_pw),
    .in_crs1   (in_crs1),
    .in_crs2   (in_crs2),
    .mul_valid (mul_valid),
    .mul_ready (mul_ready),
    .mul_l     (mul_l),
    .mul_h     (mul_h),
    .clmul     (clmul),
    .pw        (pw),
    .crs1      (crs1),
    .crs2      (crs2),
    .err       (err),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] dut_payload();
    return {mul_l, mul_h, clmul, pw, crs1, crs2};
  endfunction

  // Compare every output with the model's current state.
  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    check({tag, ".count"},     72'(count),     72'(n));
    check({tag, ".mul_valid"}, 72'(mul_valid), 72'(n != 0));
    check({tag, ".in_ready"},  72'(in_ready),  72'(n < DEPTH));
    check({tag, ".err"},       72'(err),       72'(err_m));
    check({tag, ".payload"},   dut_payload(),  (n != 0) ? mq[0] : 72'd0);
  endtask

  // Apply one rising edge to the model, using the inputs held across the edge.
  task automatic model_edge();
    bit acc, ok, pop;
    acc = in_valid && (mq.size() < DEPTH);
    ok  = ($countones(in_pw) == 1) && (in_mul_l != in_mul_h);
    pop = (mq.size() != 0) && mul_ready;
`ifdef P_MUL_ISSUE_FLUSH_EN
    if (flush) begin
      mq.delete();
      err_m = 1'b0;
      return;
    end
`endif
    if (pop) void'(mq.pop_front());
    if (acc && ok) mq.push_back({in_mul_l, in_mul_h, in_clmul, in_pw, in_crs1, in_crs2});
    err_m = acc && !ok;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic set_req(input logic v, input logic ml, input logic mh, input logic cm,
                         input logic [4:0] p, input logic [31:0] a, input logic [31:0] b);
    in_valid = v; in_mul_l = ml; in_mul_h = mh; in_clmul = cm;
    in_pw = p; in_crs1 = a; in_crs2 = b;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    mul_ready = 1'b0;
`ifdef P_MUL_ISSUE_FLUSH_EN
    flush = 1'b0;
`endif
    mq.delete();
    err_m = 1'b0;
    #1;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    logic [71:0] pa;
    do_reset();
    check_all("reset");

    // Single push, then observe it at the head.
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 5'b00001, 32'h3, 32'h5);
    cycle();
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    check_all("single_push");
    check("single_payload", dut_payload(), {1'b1, 1'b0, 1'b0, 5'b00001, 32'h3, 32'h5});
    check("single_count", 72'(count), 72'd1);

    // Three pushes while stalled: only two are accepted and the head is held.
    do_reset();
    pa = {1'b1, 1'b0, 1'b0, 5'b00100, 32'hAAAA0001, 32'h11};
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 5'b00100, 32'hAAAA0001, 32'h11);
    cycle();
    check_all("fill1");
    set_req(1'b1, 1'b0, 1'b1, 1'b1, 5'b01000, 32'hBBBB0002, 32'h22);
    cycle();
    check_all("fill2");
    set_req(1'b1, 1'b1, 1'b0, 1'b1, 5'b10000, 32'hCCCC0003, 32'h33);
    check("full_in_ready", 72'(in_ready), 72'd0);
    cycle();
    check_all("full_hold");
    check("full_head", dut_payload(), pa);
    check("full_count", 72'(count), 72'(DEPTH));

    // Release the stall with the third request still pending: drain in order.
    mul_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (i == 1) set_req(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      check_all("drain");
    end

    // Rejected requests: bad width, both halves selected, zero width.
    do_reset();
    set_req(1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 32'h7, 32'h9);
    cycle();
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 5'b00011, 32'h1, 32'h2);
    cycle();
    check_all("err_pw");
    check("err_pulse", 72'(err), 72'd1);
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    cycle();
    check_all("err_clear");
    set_req(1'b1, 1'b1, 1'b1, 1'b0, 5'b00001, 32'h1, 32'h2);
    cycle();
    check_all("err_lh");
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 32'h1, 32'h2);
    cycle();
    check_all("err_zero");

    // Asynchronous reset with a full FIFO, checked between clock edges.
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 5'b00001, 32'h44, 32'h55);
    cycle();
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    check("pre_async_count", 72'(count), 72'd2);
    #2 resetn = 1'b0;
    #1;
    check("async_count", 72'(count), 72'd0);
    check("async_valid", 72'(mul_valid), 72'd0);
    check("async_payload", dut_payload(), 72'd0);
    check("async_err", 72'(err), 72'd0);
    do_reset();
    check_all("after_async");

`ifdef P_MUL_ISSUE_FLUSH_EN
    // Flush with a same-cycle push: the FIFO ends up empty.
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 5'b00001, 32'h10, 32'h20);
    cycle();
    cycle();
    check("pre_flush_count", 72'(count), 72'd2);
    set_req(1'b1, 1'b0, 1'b1, 1'b0, 5'b00010, 32'h30, 32'h40);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    check_all("flush");
    check("flush_valid", 72'(mul_valid), 72'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] p;
      if ($urandom_range(0, 3) == 0) p = 5'($urandom);
      else p = 5'd1 << $urandom_range(0, 4);
      set_req(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom), 1'($urandom), p,
              $urandom, $urandom);
      mul_ready = 1'($urandom_range(0, 2) == 0);
`ifdef P_MUL_ISSUE_FLUSH_EN
      flush = 1'($urandom_range(0, 30) == 0);
`endif
      cycle();
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
